// File: rtl/arm_operand_pkg.sv
// arm_operand_pkg: shared immediate-field layout, search depth and encoder state enum.
package arm_operand_pkg;

    localparam int ROT_STEPS = 16;
    localparam int ROT_MSB   = 11;
    localparam int ROT_LSB   = 8;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

endpackage

// File: rtl/imm_operand_encoder_rotl_even.sv
// rotl_even: combinational 32-bit rotate-left by twice the 4-bit rotation index.
module rotl_even (
    input  logic [31:0] data_i,
    input  logic [3:0]  rot_i,
    output logic [31:0] data_o
);

    logic [4:0] sh;

    assign sh     = {rot_i, 1'b0};
    assign data_o = (data_i << sh) | (data_i >> (6'd32 - {1'b0, sh}));

endmodule

// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: tests one even rotation per clock for an 8-bit immediate encoding of a constant.
// Define IMM_ENC_MVN_EN to retry the search on ~value (MVN form) after a direct miss.
module imm_operand_encoder
    import arm_operand_pkg::*;
#(
    parameter int ROT_STEPS = arm_operand_pkg::ROT_STEPS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        inverted,
    output logic [11:0] shifter_operand
);

    state_t      state_q;
    logic [31:0] value_q;
    logic [3:0]  r_q;
    logic        busy_q;
    logic        done_q;
    logic        found_q;
    logic [11:0] operand_q;
    logic [31:0] cand;
    logic        match;
    logic        last;

`ifdef IMM_ENC_MVN_EN
    logic inv_phase_q;
    logic inverted_q;
    assign inverted = inverted_q;
`else
    assign inverted = 1'b0;
`endif

    rotl_even u_rot (
        .data_i (value_q),
        .rot_i  (r_q),
        .data_o (cand)
    );

    assign match           = cand[31:IMM_MSB+1] == '0;
    assign last            = r_q == 4'(ROT_STEPS - 1);
    assign busy            = busy_q;
    assign done            = done_q;
    assign found           = found_q;
    assign shifter_operand = operand_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            value_q   <= '0;
            r_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            operand_q <= '0;
`ifdef IMM_ENC_MVN_EN
            inv_phase_q <= 1'b0;
            inverted_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SEARCH;
                    value_q <= value;
                    r_q     <= '0;
                    busy_q  <= 1'b1;
`ifdef IMM_ENC_MVN_EN
                    inv_phase_q <= 1'b0;
`endif
                end
                SEARCH: begin
                    if (match) begin
                        state_q                   <= DONE;
                        done_q                    <= 1'b1;
                        found_q                   <= 1'b1;
                        operand_q[ROT_MSB:ROT_LSB] <= r_q;
                        operand_q[IMM_MSB:IMM_LSB] <= cand[IMM_MSB:IMM_LSB];
`ifdef IMM_ENC_MVN_EN
                        inverted_q <= inv_phase_q;
`endif
                    end
`ifdef IMM_ENC_MVN_EN
                    else if (last && !inv_phase_q) begin
                        inv_phase_q <= 1'b1;
                        value_q     <= ~value_q;
                        r_q         <= '0;
                    end
`endif
                    else if (last) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        found_q   <= 1'b0;
                        operand_q <= '0;
`ifdef IMM_ENC_MVN_EN
                        inverted_q <= 1'b0;
`endif
                    end else begin
                        r_q <= r_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
